uart_cmd_parser: RTL

//   Frame parser and write sequencer behind the UART receiver. Consumes received bytes
//   (valid pulse + byte), hunts for a sync byte, buffers a length-prefixed, XOR-checked

---
 rtl/uart_cmd_parser_if.sv | 23 ++
 rtl/uart_cmd_parser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_if.sv
// Register-file write port: one valid/ready handshake carrying address and data.
interface uart_cmd_parser_if #(
   parameter int ADDR_W = 7
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART frame parser: SYNC, CMD, LEN, payload, XOR checksum, then one
// register write per payload byte through the write-port handshake.
module uart_cmd_parser #(
   parameter int         MAX_LEN      = 8,
   parameter int         TIMEOUT_CLKS = 13900,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         ADDR_W       = 7
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   uart_cmd_parser_if.master wr,
   output logic       o_Busy,
   output logic       o_Frame_Ok,
   output logic       o_Frame_Err,
   output logic [1:0] o_Err_Code,
   output logic [7:0] o_Err_Count
);

   localparam logic [2:0] S_HUNT    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_LEN     = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_CSUM    = 3'd4;
   localparam logic [2:0] S_DRAIN   = 3'd5;

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

   logic [2:0]        state_q;
   logic [2:0]        state_d;
   logic [ADDR_W-1:0] base_q;
   logic [7:0]        xor_q;
   logic [7:0]        len_q;
   logic [7:0]        idx_q;
   logic [7:0]        k_q;
   logic [TW-1:0]     tcnt_q;
   logic [7:0]        mem_q [0:(1<<IW)-1];

   logic       in_frame;
   logic       tmo;
   logic       wr_fire;
   logic       err_fire;
   logic [1:0] err_val;
   logic       ok_fire;

   assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CSUM);
   assign tmo      = in_frame && !i_Rx_DV && (tcnt_q == T_LAST);

   assign wr.wr_valid = (state_q == S_DRAIN);
   assign wr.wr_addr  = base_q + ADDR_W'(k_q);
   assign wr.wr_data  = mem_q[k_q[IW-1:0]];
   assign wr_fire     = wr.wr_valid && wr.wr_ready;

   assign o_Busy = (state_q != S_HUNT);

   always_comb begin
      state_d  = state_q;
      err_fire = 1'b0;
      err_val  = 2'd0;
      ok_fire  = 1'b0;
      case (state_q)
         S_HUNT: begin
            if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE)
               state_d = S_CMD;
         end
         S_CMD: begin
            if (i_Rx_DV)
               state_d = S_LEN;
         end
         S_LEN: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte > LEN_MAX) begin
                  err_fire = 1'b1;
                  err_val  = 2'd1;
                  state_d  = S_HUNT;
               end else if (i_Rx_Byte == 8'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (i_Rx_DV && idx_q == len_q - 8'd1)
               state_d = S_CSUM;
         end
         S_CSUM: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte != xor_q) begin
                  err_fire = 1'b1;
                  err_val  = 2'd2;
                  state_d  = S_HUNT;
               end else if (len_q == 8'd0) begin
                  ok_fire = 1'b1;
                  state_d = S_HUNT;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (wr_fire && k_q == len_q - 8'd1) begin
               ok_fire = 1'b1;
               state_d = S_HUNT;
            end
         end
         default: state_d = S_HUNT;
      endcase
      // A byte arriving on the expiry cycle keeps the frame alive
      if (tmo) begin
         err_fire = 1'b1;
         err_val  = 2'd3;
         state_d  = S_HUNT;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= S_HUNT;
         base_q      <= '0;
         xor_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         k_q         <= '0;
         tcnt_q      <= '0;
         o_Frame_Ok  <= 1'b0;
         o_Frame_Err <= 1'b0;
         o_Err_Code  <= 2'd0;
         o_Err_Count <= 8'd0;
      end else begin
         state_q     <= state_d;
         o_Frame_Ok  <= ok_fire;
         o_Frame_Err <= err_fire;
         if (err_fire) begin
            o_Err_Code <= err_val;
            if (o_Err_Count != 8'hFF)
               o_Err_Count <= o_Err_Count + 8'd1;
         end
         if (!in_frame || i_Rx_DV)
            tcnt_q <= '0;
         else
            tcnt_q <= tcnt_q + TW'(1);
         if (i_Rx_DV) begin
            case (state_q)
               S_CMD: begin
                  base_q <= i_Rx_Byte[ADDR_W-1:0];
                  xor_q  <= i_Rx_Byte;
               end
               S_LEN: begin
                  len_q <= i_Rx_Byte;
                  xor_q <= xor_q ^ i_Rx_Byte;
                  idx_q <= 8'd0;
               end
               S_PAYLOAD: begin
                  xor_q <= xor_q ^ i_Rx_Byte;
                  idx_q <= idx_q + 8'd1;
               end
               S_CSUM: k_q <= 8'd0;
               default: ;
            endcase
         end
         if (wr_fire)
            k_q <= k_q + 8'd1;
      end
   end

   // Payload storage needs no reset; it is always written before drain
   always_ff @(posedge i_Clock) begin
      if (i_Rx_DV && state_q == S_PAYLOAD)
         mem_q[idx_q[IW-1:0]] <= i_Rx_Byte;
   end

endmodule
